stream_uart_tx: RTL and testbench



---
 rtl/stream_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_stream_uart_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_uart_tx.sv
// Byte-stream to UART transmitter: 9-bit {last,data} FIFO feeding an 8N1 serialiser.
// Define STREAM_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module stream_uart_tx #(
  parameter int DIV   = 347,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  input  logic                     int_clr,
  output logic                     uart_tx,
  output logic                     uart_int,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] RELOAD = 16'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef STREAM_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop, empty, tick;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic          tx_q, tx_d;
  logic          int_q, int_d;
`ifdef STREAM_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign head       = mem_q[rd_q];
  assign empty      = (cnt_q == '0);
  assign in_ready   = (cnt_q != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign tick       = (baud_q == '0);
  assign uart_tx    = tx_q;
  assign uart_int   = int_q;
  assign fifo_count = cnt_q;

  always_comb begin
    state_d = state_q;
    baud_d  = tick ? RELOAD : baud_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    int_d   = int_q;
    pop     = 1'b0;
`ifdef STREAM_UART_PARITY_EN
    par_d   = par_q;
`endif
    // set is evaluated after clear so it wins on a shared edge
    if (int_clr) int_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = RELOAD;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef STREAM_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef STREAM_UART_PARITY_EN
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (last_q) int_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = head[7:0];
      last_d  = head[8];
`ifdef STREAM_UART_PARITY_EN
      par_d   = ^head[7:0];
`endif
    end

    // pin level is registered from the upcoming state
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef STREAM_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= RELOAD;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      int_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
`ifdef STREAM_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      int_q   <= int_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
`ifdef STREAM_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_stream_uart_tx.sv
// Self-checking bench for stream_uart_tx: waveform tables, pin decoder, flood and reset tests.
// Honours STREAM_UART_PARITY_EN to expect 11-bit frames.
module tb_stream_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef STREAM_UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       int_clr = 1'b0;
  logic       tx;
  logic       uart_int;
  logic [2:0] fifo_count;

  stream_uart_tx #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clock      (clk),
    .reset      (rst),
    .in_ready   (in_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .int_clr    (int_clr),
    .uart_tx    (tx),
    .uart_int   (uart_int),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame bit i of byte d: start, 8 data LSB first, optional parity, stop.
  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (FL == 11 && i == 9) return ^d;
    return 1'b1;
  endfunction

  // Independent pin decoder: finds start bits, samples mid-bit.
  int          starts = 0;
  logic [7:0]  rxq[$];
  logic [FL-1:0] mon_b;
  bit          mon_abort;

  initial forever begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      starts++;
      mon_b     = '0;
      mon_abort = 1'b0;
      for (int c = 1; c < FL*DIV; c++) begin
        @(negedge clk);
        if (rst) mon_abort = 1'b1;
        if (!mon_abort && (c % DIV) == DIV/2) mon_b[c/DIV] = tx;
      end
      if (!mon_abort) begin
        rxq.push_back(mon_b[8:1]);
        chk("rx_stop", 32'(mon_b[FL-1]), 1);
`ifdef STREAM_UART_PARITY_EN
        chk("rx_par", 32'(mon_b[9]), 32'(^mon_b[8:1]));
`endif
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the push edge of a byte entering an empty idle FIFO.
  task automatic check_frame(input logic [7:0] d, input logic ei,
                             input logic clr, input string nm);
    for (int i = 0; i < FL*DIV; i++) begin
      @(posedge clk);
      #1;
      chk({nm, "_tx"}, 32'(tx), 32'(fbit(d, i/DIV)));
    end
    if (clr) int_clr = 1'b1;
    @(posedge clk);
    #1;
    int_clr = 1'b0;
    chk({nm, "_idle"}, 32'(tx), 1);
    chk({nm, "_int"}, 32'(uart_int), 32'(ei));
  endtask

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       ei;
  } vec_t;

  vec_t       tv[4];
  logic [7:0] bb[3];
  logic [7:0] sent[$];
  int         acc, s0, mcnt;
  bit         saw_full, acc_now;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{8'hA5, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b0, 1'b0};
    tv[2] = '{8'h07, 1'b1, 1'b1};
    tv[3] = '{8'hC3, 1'b0, 1'b1};

    #12;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_int", 32'(uart_int), 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      push(tv[i].d, tv[i].l);
      chk("push_cnt", 32'(fifo_count), 1);
      check_frame(tv[i].d, tv[i].ei, 1'b0, $sformatf("tv%0d", i));
    end

    int_clr = 1'b1;
    @(posedge clk);
    #1;
    int_clr = 1'b0;
    chk("clr_lone1", 32'(uart_int), 0);

    // Three contiguous frames, last flag on the third.
    bb[0] = 8'h81; bb[1] = 8'h00; bb[2] = 8'hFF;
    in_valid = 1'b1; in_data = bb[0]; in_last = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        in_data = bb[1];
        @(posedge clk);
        #1;
        in_data = bb[2];
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      begin
        for (int i = 0; i < 3*FL*DIV; i++) begin
          @(posedge clk);
          #1;
          chk("b2b_tx", 32'(tx),
              32'(fbit(bb[i/(FL*DIV)], (i % (FL*DIV))/DIV)));
          if (i == 3*FL*DIV-1) chk("b2b_int_pre", 32'(uart_int), 0);
        end
        @(posedge clk);
        #1;
        chk("b2b_int", 32'(uart_int), 1);
        chk("b2b_idle", 32'(tx), 1);
      end
    join

    // Clear coincides with a new set: set must win.
    push(8'h6E, 1'b1);
    check_frame(8'h6E, 1'b1, 1'b1, "setwin");
    int_clr = 1'b1;
    @(posedge clk);
    #1;
    int_clr = 1'b0;
    chk("clr_lone2", 32'(uart_int), 0);

    // Flood with in_valid held high; model count = accepted - started.
    rxq.delete();
    s0 = starts; acc = 0; saw_full = 1'b0;
    in_last = 1'b0; in_data = 8'($urandom); in_valid = 1'b1;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      #1;
      mcnt = acc - (starts - s0);
      chk("fl_cnt", 32'(fifo_count), mcnt);
      chk("fl_rdy", 32'(in_ready), 32'(mcnt != DEPTH));
      if (mcnt == DEPTH) saw_full = 1'b1;
      acc_now = (mcnt != DEPTH);
      if (acc_now) begin
        sent.push_back(in_data);
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc_now) in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    chk("fl_saw_full", 32'(saw_full), 1);
    for (int w = 0; w < 3000 && rxq.size() < sent.size(); w++)
      @(posedge clk);
    chk("fl_drain", rxq.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rxq.size(); i++)
      chk("fl_byte", 32'(rxq[i]), 32'(sent[i]));
    repeat (2) @(posedge clk);
    #1;
    chk("fl_idle", 32'(tx), 1);

    // Reset midway through data bit 3 with two bytes queued.
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    @(posedge clk);
    #1;
    in_data = 8'h22;
    @(posedge clk);
    #1;
    in_data = 8'h33;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4*DIV) @(posedge clk);
    #2;
    chk("pre_rst_cnt", 32'(fifo_count), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_cnt", 32'(fifo_count), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20*DIV; i++) begin
      @(posedge clk);
      #1;
      chk("quiet_tx", 32'(tx), 1);
      chk("quiet_cnt", 32'(fifo_count), 0);
    end
    push(8'h5A, 1'b0);
    check_frame(8'h5A, 1'b0, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
